// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant bundle between the bus masters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if;
    logic [3:0] req_;
    logic [3:0] grnt_;
    logic [1:0] m_sel;
    logic       owned;
    logic       tmo;
    logic [1:0] tmo_id;

    // Arbiter side
    modport slave (
        input  req_,
        output grnt_,
        output m_sel,
        output owned,
        output tmo,
        output tmo_id
    );

    // Requesting-master side
    modport master (
        output req_,
        input  grnt_,
        input  m_sel,
        input  owned,
        input  tmo,
        input  tmo_id
    );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master round-robin bus arbiter with hold-time revocation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 256
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bus_arbiter_if.slave        bus
);

    localparam logic [15:0] c_HOLD_LIMIT = 16'(MAX_HOLD - 32'd1);
    localparam bit          c_TMO_EN     = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;
    logic [15:0] r_hold_cnt;
    logic [3:0]  r_grnt;
    logic [1:0]  r_m_sel;
    logic        r_tmo;
    logic [1:0]  r_tmo_id;

    state_t      w_state;
    logic [1:0]  w_owner;
    logic [1:0]  w_ptr;
    logic [15:0] w_hold_cnt;
    logic [3:0]  w_grnt;
    logic [1:0]  w_m_sel;
    logic        w_tmo;
    logic [1:0]  w_tmo_id;

    logic        w_found;
    logic [1:0]  w_pick;

    // Returns {found, index}; scanning backwards leaves the lowest offset from start as winner.
    function automatic logic [2:0] arbitrate(input logic [3:0] req_n, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = {1'b0, start};
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (!req_n[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    always_comb begin
        {w_found, w_pick} = arbitrate(bus.req_, r_ptr);
    end

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_ptr      = r_ptr;
        w_hold_cnt = r_hold_cnt;
        w_grnt     = r_grnt;
        w_m_sel    = r_m_sel;
        w_tmo      = 1'b0;
        w_tmo_id   = r_tmo_id;

        case (r_state)
            IDLE: begin
                w_grnt = 4'b1111;
                if (w_found) begin
                    w_grnt     = ~(4'b0001 << w_pick);
                    w_owner    = w_pick;
                    w_m_sel    = w_pick;
                    w_hold_cnt = 16'd0;
                    w_ptr      = w_pick + 2'd1;
                    w_state    = GRANT;
                end
            end
            GRANT: begin
                if (bus.req_[r_owner]) begin
                    // Release wins over a coincident timeout; hand over without an idle cycle.
                    if (w_found) begin
                        w_grnt     = ~(4'b0001 << w_pick);
                        w_owner    = w_pick;
                        w_m_sel    = w_pick;
                        w_hold_cnt = 16'd0;
                        w_ptr      = w_pick + 2'd1;
                    end else begin
                        w_grnt  = 4'b1111;
                        w_state = IDLE;
                    end
                end else if (c_TMO_EN && (r_hold_cnt == c_HOLD_LIMIT)) begin
                    w_grnt   = 4'b1111;
                    w_tmo    = 1'b1;
                    w_tmo_id = r_owner;
                    w_state  = IDLE;
                end else if (r_hold_cnt != 16'hFFFF) begin
                    w_hold_cnt = r_hold_cnt + 16'd1;
                end
            end
            default: begin
                w_grnt  = 4'b1111;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 2'd0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 16'd0;
            r_grnt     <= 4'b1111;
            r_m_sel    <= 2'd0;
            r_tmo      <= 1'b0;
            r_tmo_id   <= 2'd0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_ptr      <= w_ptr;
            r_hold_cnt <= w_hold_cnt;
            r_grnt     <= w_grnt;
            r_m_sel    <= w_m_sel;
            r_tmo      <= w_tmo;
            r_tmo_id   <= w_tmo_id;
        end
    end

    assign bus.grnt_  = r_grnt;
    assign bus.m_sel  = r_m_sel;
    assign bus.owned  = ~&r_grnt;
    assign bus.tmo    = r_tmo;
    assign bus.tmo_id = r_tmo_id;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed scoreboard bench for bus_arbiter with MAX_HOLD = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    typedef struct {
        logic [3:0] grnt;
        logic [1:0] msel;
        logic       tmo;
        logic [1:0] tid;
        string      tag;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   sb[$];
    int     n_cmp;
    int     n_err;
    string  cur_tag;

    bus_arbiter_if bus ();

    bus_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] req, input logic r,
                        input logic [3:0] g, input logic [1:0] ms,
                        input logic t, input logic [1:0] tid);
        exp_t e;
        @(negedge clk);
        bus.req_ = req;
        rst      = r;
        e.grnt   = g;
        e.msel   = ms;
        e.tmo    = t;
        e.tid    = tid;
        e.tag    = cur_tag;
        sb.push_back(e);
    endtask

    // Monitor: one response per active edge, compared against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("grnt_",  e.tag, int'(bus.grnt_),  int'(e.grnt));
            check("m_sel",  e.tag, int'(bus.m_sel),  int'(e.msel));
            check("owned",  e.tag, int'(bus.owned),  int'(~&e.grnt));
            check("tmo",    e.tag, int'(bus.tmo),    int'(e.tmo));
            check("tmo_id", e.tag, int'(bus.tmo_id), int'(e.tid));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.req_ = 4'b1111;
        cur_tag  = "reset";
        step(4'b1111, 1, 4'b1111, 0, 0, 0);
        step(4'b1111, 1, 4'b1111, 0, 0, 0);

        cur_tag = "single";
        step(4'b1110, 0, 4'b1110, 0, 0, 0);
        step(4'b1110, 0, 4'b1110, 0, 0, 0);
        step(4'b1111, 0, 4'b1111, 0, 0, 0);
        step(4'b1111, 0, 4'b1111, 0, 0, 0);

        // Reset again so the pointer restarts at master 0.
        cur_tag = "rr";
        step(4'b1111, 1, 4'b1111, 0, 0, 0);
        step(4'b0000, 0, 4'b1110, 0, 0, 0);
        step(4'b0000, 0, 4'b1110, 0, 0, 0);
        step(4'b0000, 0, 4'b1110, 0, 0, 0);
        step(4'b0001, 0, 4'b1101, 1, 0, 0);
        step(4'b0000, 0, 4'b1101, 1, 0, 0);
        step(4'b0000, 0, 4'b1101, 1, 0, 0);
        step(4'b0010, 0, 4'b1011, 2, 0, 0);
        step(4'b0000, 0, 4'b1011, 2, 0, 0);
        step(4'b0000, 0, 4'b1011, 2, 0, 0);
        step(4'b0100, 0, 4'b0111, 3, 0, 0);
        step(4'b0000, 0, 4'b0111, 3, 0, 0);
        step(4'b0000, 0, 4'b0111, 3, 0, 0);
        step(4'b1000, 0, 4'b1110, 0, 0, 0);
        step(4'b0000, 0, 4'b1110, 0, 0, 0);

        // Owner 3 releases with masters 0 and 2 requesting: pointer wraps to 0.
        cur_tag = "wrap";
        step(4'b0111, 0, 4'b0111, 3, 0, 0);
        step(4'b0111, 0, 4'b0111, 3, 0, 0);
        step(4'b1010, 0, 4'b1110, 0, 0, 0);
        step(4'b1111, 0, 4'b1111, 0, 0, 0);

        cur_tag = "timeout";
        step(4'b1011, 0, 4'b1011, 2, 0, 0);
        step(4'b1011, 0, 4'b1011, 2, 0, 0);
        step(4'b1011, 0, 4'b1011, 2, 0, 0);
        step(4'b1011, 0, 4'b1011, 2, 0, 0);
        step(4'b1011, 0, 4'b1111, 2, 1, 2);
        step(4'b1011, 0, 4'b1011, 2, 0, 2);

        // Master 1 releases on the cycle its hold count reaches MAX_HOLD-1.
        cur_tag = "tmo_vs_rel";
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1011, 0, 4'b1011, 2, 0, 2);

        cur_tag = "rst_mid";
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1101, 0, 4'b1101, 1, 0, 2);
        step(4'b1101, 1, 4'b1111, 0, 0, 0);
        step(4'b1001, 0, 4'b1101, 1, 0, 0);
        step(4'b1111, 0, 4'b1111, 1, 0, 0);
        step(4'b1111, 0, 4'b1111, 1, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
